pwm_capture: RTL and testbench

PWM capture block: receive-side counterpart to the team's free-running PWM generator. It synchronizes an asynchronous PWM input and measures, in clk cycles, the high time and full period of each PWM cycle. Each complete measurement is published with a one-cycle valid strobe. Signals with no edges (stuck high/low, or a period too long to count) are flagged. It sits on the feedback path of fan/motor/LED control loops, or in loopback self-test of a PWM generator.

---
 rtl/pwm_capture_if.sv | 33 +++
 rtl/pwm_capture.sv | 124 ++++++++++++
 tb/tb_pwm_capture.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Port bundle for pwm_capture: control and PWM input toward the capture block,
// measurement results and status flags back to the consumer.
interface pwm_capture_if #(
    parameter int unsigned CNT_WIDTH = 16
) ();
    logic                 enable;
    logic                 pwm_in;
    logic [CNT_WIDTH-1:0] high_cnt;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic                 meas_valid;
    logic                 stuck_high;
    logic                 stuck_low;

    modport master (
        output enable,
        output pwm_in,
        input  high_cnt,
        input  period_cnt,
        input  meas_valid,
        input  stuck_high,
        input  stuck_low
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output high_cnt,
        output period_cnt,
        output meas_valid,
        output stuck_high,
        output stuck_low
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes pwm_in and measures high time and rise-to-rise period in clk
// cycles, publishing each completed cycle with a one-cycle strobe; flags edge-less inputs.
module pwm_capture #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          reset_n,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {StArm, StMeasHigh, StMeasLow} state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d_q;
    logic                   rise, fall, timeout;
    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   high_lat_q, high_lat_d;
    logic [CNT_WIDTH-1:0]   high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0]   period_cnt_q, period_cnt_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   stuck_high_q, stuck_high_d;
    logic                   stuck_low_q, stuck_low_d;

    // Synchronizer keeps running while disabled so re-enable sees a settled level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            s_d_q  <= s;
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d_q;
    assign fall    = ~s & s_d_q;
    assign timeout = (cnt_q == CntMax) && !rise && !fall;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        high_lat_d   = high_lat_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        meas_valid_d = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;

        if (!bus.enable) begin
            state_d      = StArm;
            cnt_d        = '0;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
        end else begin
            // Counter saturates at max; only a rise restarts it.
            if (rise) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end

            case (state_q)
                StArm: begin
                    if (rise) state_d = StMeasHigh;
                end
                StMeasHigh: begin
                    if (fall) begin
                        high_lat_d = cnt_q;
                        state_d    = StMeasLow;
                    end
                end
                StMeasLow: begin
                    if (rise) begin
                        high_cnt_d   = high_lat_q;
                        period_cnt_d = cnt_q;
                        meas_valid_d = 1'b1;
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                        state_d      = StMeasHigh;
                    end
                end
                default: state_d = StArm;
            endcase

            if (timeout) begin
                state_d = StArm;
                if (s) stuck_high_d = 1'b1;
                else   stuck_low_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StArm;
            cnt_q        <= '0;
            high_lat_q   <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            high_lat_q   <= high_lat_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            meas_valid_q <= meas_valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign bus.high_cnt   = high_cnt_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.stuck_high = stuck_high_q;
    assign bus.stuck_low  = stuck_low_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a 16-bit and an 8-bit instance share one PWM source (a loopback
// generator with programmable period/duty, or a static level).
module tb_pwm_capture;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
    logic level   = 1'b0;
    logic gen_en  = 1'b0;
    int   gen_period = 256;
    int   gen_duty   = 64;
    int   pwm_ctr    = 0;
    logic pwm;

    int checks = 0;
    int errors = 0;

    pwm_capture_if #(.CNT_WIDTH(16)) bus16 ();
    pwm_capture_if #(.CNT_WIDTH(8))  bus8 ();

    pwm_capture #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    pwm_capture #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pwm_ctr <= (pwm_ctr + 1 >= gen_period) ? 0 : pwm_ctr + 1;

    assign pwm          = gen_en ? (pwm_ctr < gen_duty) : level;
    assign bus16.pwm_in = pwm;
    assign bus16.enable = enable;
    assign bus8.pwm_in  = pwm;
    assign bus8.enable  = enable;

    typedef struct {
        int duty;
        int exp_high;
        int exp_period;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits for meas_valid on the selected instance; an expired budget counts as a failure.
    task automatic wait_valid(input bit use8, input int budget, input string name,
                              output int waited);
        waited = 0;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if (use8 ? bus8.meas_valid : bus16.meas_valid) return;
        end
        check({name, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int  w;
        int  nvalid;
        bit  held_ok;

        vecs[0] = '{duty: 64,  exp_high: 64,  exp_period: 256};
        vecs[1] = '{duty: 1,   exp_high: 1,   exp_period: 256};
        vecs[2] = '{duty: 128, exp_high: 128, exp_period: 256};
        vecs[3] = '{duty: 255, exp_high: 255, exp_period: 256};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset high_cnt", 32'(bus16.high_cnt), 32'd0);
        check("reset period_cnt", 32'(bus16.period_cnt), 32'd0);
        check("reset meas_valid", 32'(bus16.meas_valid), 32'd0);
        check("reset stuck16", 32'({bus16.stuck_high, bus16.stuck_low}), 32'd0);
        check("reset stuck8", 32'({bus8.stuck_high, bus8.stuck_low}), 32'd0);

        reset_n = 1'b1;
        gen_en  = 1'b1;
        enable  = 1'b1;

        // Loopback duty sweep on the 16-bit instance
        for (int i = 0; i < 4; i++) begin
            gen_duty = vecs[i].duty;
            wait_valid(1'b0, 600, "settle", w);
            wait_valid(1'b0, 600, "settle", w);
            wait_valid(1'b0, 600, "meas", w);
            check($sformatf("high duty=%0d", vecs[i].duty), 32'(bus16.high_cnt),
                  32'(vecs[i].exp_high));
            check($sformatf("period duty=%0d", vecs[i].duty), 32'(bus16.period_cnt),
                  32'(vecs[i].exp_period));
            check($sformatf("flags duty=%0d", vecs[i].duty),
                  32'({bus16.stuck_high, bus16.stuck_low}), 32'd0);
            @(negedge clk);
            check($sformatf("valid one cycle duty=%0d", vecs[i].duty),
                  32'(bus16.meas_valid), 32'd0);
            wait_valid(1'b0, 600, "spacing", w);
            check($sformatf("valid spacing duty=%0d", vecs[i].duty), 32'(w + 1),
                  32'(vecs[i].exp_period));
        end

        // Stuck low on the 8-bit instance
        enable = 1'b0;
        gen_en = 1'b0;
        level  = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (bus8.meas_valid) nvalid++;
        end
        check("stuck_low not yet", 32'(bus8.stuck_low), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus8.meas_valid) nvalid++;
        end
        check("stuck_low set", 32'(bus8.stuck_low), 32'd1);
        check("stuck_high clear on low", 32'(bus8.stuck_high), 32'd0);
        check("no valid while stuck low", 32'(nvalid), 32'd0);

        gen_period = 128;
        gen_duty   = 64;
        gen_en     = 1'b1;
        wait_valid(1'b1, 600, "recover low", w);
        check("stuck_low cleared by valid", 32'(bus8.stuck_low), 32'd0);
        wait_valid(1'b1, 300, "recover low meas", w);
        check("recover low high", 32'(bus8.high_cnt), 32'd64);
        check("recover low period", 32'(bus8.period_cnt), 32'd128);

        // Stuck high on the 8-bit instance, then 10 high / 20 low
        gen_en = 1'b0;
        level  = 1'b1;
        repeat (300) @(negedge clk);
        check("stuck_high set", 32'(bus8.stuck_high), 32'd1);
        check("stuck_low clear on high", 32'(bus8.stuck_low), 32'd0);
        gen_period = 30;
        gen_duty   = 10;
        gen_en     = 1'b1;
        wait_valid(1'b1, 200, "recover high", w);
        check("recover high high", 32'(bus8.high_cnt), 32'd10);
        check("recover high period", 32'(bus8.period_cnt), 32'd30);
        check("stuck_high cleared by valid", 32'(bus8.stuck_high), 32'd0);

        // Enable dropped mid-period
        gen_period = 256;
        gen_duty   = 64;
        repeat (3) wait_valid(1'b0, 600, "pre-disable", w);
        check("pre-disable high", 32'(bus16.high_cnt), 32'd64);
        check("pre-disable period", 32'(bus16.period_cnt), 32'd256);
        repeat (100) @(negedge clk);
        enable  = 1'b0;
        held_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus16.meas_valid || bus16.high_cnt != 16'd64 || bus16.period_cnt != 16'd256)
                held_ok = 1'b0;
        end
        check("disabled flags8", 32'({bus8.stuck_high, bus8.stuck_low}), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus16.meas_valid || bus16.high_cnt != 16'd64 || bus16.period_cnt != 16'd256 ||
                bus16.stuck_high || bus16.stuck_low)
                held_ok = 1'b0;
        end
        check("disable holds results, no early valid", 32'(held_ok), 32'd1);
        wait_valid(1'b0, 300, "re-enable", w);
        check("re-enable high", 32'(bus16.high_cnt), 32'd64);
        check("re-enable period", 32'(bus16.period_cnt), 32'd256);

        // Asynchronous reset in the low phase
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async reset high_cnt", 32'(bus16.high_cnt), 32'd0);
        check("async reset period_cnt", 32'(bus16.period_cnt), 32'd0);
        check("async reset valid/flags",
              32'({bus16.meas_valid, bus16.stuck_high, bus16.stuck_low}), 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        nvalid  = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (bus16.meas_valid) nvalid++;
        end
        check("no valid before second rise", 32'(nvalid), 32'd0);
        wait_valid(1'b0, 400, "post-reset", w);
        check("post-reset high", 32'(bus16.high_cnt), 32'd64);
        check("post-reset period", 32'(bus16.period_cnt), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
